// File: rtl/cluster_pkg.sv
// Shared constants and state type for the cluster_1 input vector loader.
package cluster_pkg;

  localparam int VEC_W     = 1894;
  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 60;
  localparam int LAST_BITS = 6;
  localparam int IDX_W     = 6;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    FILL,
    FULL,
    DRAIN
  } loader_state_t;

endpackage

// File: rtl/cluster_word_slicer.sv
// Decodes the current word index into a one-hot slice write enable.
// Indices past the final slice never produce an enable, and the final
// slice is flagged separately so the caller can store only its valid bits.
module cluster_word_slicer
  import cluster_pkg::*;
(
  input  logic                 writeEn_i,
  input  logic [IDX_W-1:0]     idx_i,
  output logic [NUM_WORDS-1:0] sliceWe_o,
  output logic                 lastSlice_o
);

  // One-hot enable for the slice addressed by idx_i, gated by writeEn_i.
  always_comb begin
    sliceWe_o   = '0;
    lastSlice_o = (idx_i == LAST_IDX);
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (writeEn_i && (idx_i == IDX_W'(w))) begin
        sliceWe_o[w] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cluster_input_loader.sv
// Assembles the 1894-bit cluster_1 input vector from a 32-bit word stream
// and holds it stable for the downstream combinational output-bit modules.
// Malformed frames (early or missing s_last) raise a one-cycle err_len.
module cluster_input_loader
  import cluster_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  input  logic              flush,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [VEC_W-1:0]  m_vec,
  output logic              err_len,
  output logic [15:0]       frame_cnt
);

  loader_state_t         state_q,    state_d;
  logic [IDX_W-1:0]      wordIdx_q,  wordIdx_d;
  logic [VEC_W-1:0]      vec_q,      vec_d;
  logic                  errLen_q,   errLen_d;
  logic [15:0]           frameCnt_q, frameCnt_d;

  logic                  inXfer;
  logic                  outXfer;
  logic                  writeEn;
  logic [NUM_WORDS-1:0]  sliceWe;
  logic                  lastSlice;

  assign s_ready   = rst_n && (state_q != FULL);
  assign m_valid   = (state_q == FULL);
  assign m_vec     = vec_q;
  assign err_len   = errLen_q;
  assign frame_cnt = frameCnt_q;

  assign inXfer  = s_valid && s_ready;
  assign outXfer = m_valid && m_ready;
  assign writeEn = inXfer && (state_q == FILL) && !flush;

  cluster_word_slicer u_slicer (
    .writeEn_i   (writeEn),
    .idx_i       (wordIdx_q),
    .sliceWe_o   (sliceWe),
    .lastSlice_o (lastSlice)
  );

  // Merge the accepted word into its slice; the final slice keeps only its low bits.
  always_comb begin
    vec_d = vec_q;
    for (int w = 0; w < NUM_WORDS - 1; w++) begin
      if (sliceWe[w]) begin
        vec_d[w*WORD_W +: WORD_W] = s_data;
      end
    end
    if (sliceWe[NUM_WORDS-1]) begin
      vec_d[VEC_W-1 -: LAST_BITS] = s_data[LAST_BITS-1:0];
    end
  end

  // Frame FSM: word indexing, framing errors, hand-off and flush handling.
  always_comb begin
    state_d    = state_q;
    wordIdx_d  = wordIdx_q;
    errLen_d   = 1'b0;
    frameCnt_d = frameCnt_q;

    if (flush) begin
      state_d   = FILL;
      wordIdx_d = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (inXfer) begin
            if (lastSlice) begin
              wordIdx_d = '0;
              if (s_last) begin
                state_d = FULL;
              end else begin
                errLen_d = 1'b1;
                state_d  = DRAIN;
              end
            end else if (s_last) begin
              errLen_d  = 1'b1;
              wordIdx_d = '0;
            end else begin
              wordIdx_d = wordIdx_q + IDX_W'(1);
            end
          end
        end
        FULL: begin
          if (outXfer) begin
            state_d    = FILL;
            wordIdx_d  = '0;
            frameCnt_d = frameCnt_q + 16'd1;
          end
        end
        DRAIN: begin
          if (inXfer && s_last) begin
            state_d   = FILL;
            wordIdx_d = '0;
          end
        end
        default: begin
          state_d   = FILL;
          wordIdx_d = '0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FILL;
      wordIdx_q  <= '0;
      vec_q      <= '0;
      errLen_q   <= 1'b0;
      frameCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wordIdx_q  <= wordIdx_d;
      vec_q      <= vec_d;
      errLen_q   <= errLen_d;
      frameCnt_q <= frameCnt_d;
    end
  end

endmodule

// File: tb/tb_cluster_input_loader.sv
// Directed-plus-random bench for cluster_input_loader with a word-array model.
module tb_cluster_input_loader;
  import cluster_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              s_last;
  logic              flush;
  logic              m_valid;
  logic              m_ready;
  logic [VEC_W-1:0]  m_vec;
  logic              err_len;
  logic [15:0]       frame_cnt;

  int total = 0;
  int bad   = 0;
  int expCnt = 0;
  logic [31:0] words [NUM_WORDS];
  logic [VEC_W-1:0] held;

  cluster_input_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .flush     (flush),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_vec     (m_vec),
    .err_len   (err_len),
    .frame_cnt (frame_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference vector: word k occupies bits 32k+31..32k, anything past the top bit is lost.
  function automatic logic [VEC_W-1:0] modelVec();
    logic [VEC_W-1:0] v;
    int pos;
    v = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      for (int b = 0; b < WORD_W; b++) begin
        pos = k * WORD_W + b;
        if (pos < VEC_W) v[pos] = words[k][b];
      end
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkVec(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
    int fb;
    fb = 0;
    for (int i = VEC_W - 1; i >= 0; i--) begin
      if (obs[i] !== exp[i]) fb = i;
    end
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s first differing bit=%0d observed=%b expected=%b", tag, fb, obs[fb], exp[fb]);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic last);
    checkOutput("s_ready_accept", {31'b0, s_ready}, 32'd1);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = $urandom;
  endtask

  task automatic pushFrame(input int n, input int lastAt, input bit indexData);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d = indexData ? 32'(i) : $urandom;
      if (i < NUM_WORDS) words[i] = d;
      applyStimulus(d, i == lastAt);
    end
  endtask

  // Called right after the last word of a good frame, with m_ready low.
  task automatic deliverCheck(input int delay);
    logic [VEC_W-1:0] expVec;
    expVec = modelVec();
    checkOutput("m_valid_rise", {31'b0, m_valid}, 32'd1);
    checkOutput("s_ready_full", {31'b0, s_ready}, 32'd0);
    checkOutput("err_len_good", {31'b0, err_len}, 32'd0);
    checkVec("m_vec_frame", m_vec, expVec);
    for (int j = 0; j < delay; j++) begin
      s_valid = 1'b1;
      tick();
      checkOutput("m_valid_hold", {31'b0, m_valid}, 32'd1);
      checkOutput("s_ready_hold", {31'b0, s_ready}, 32'd0);
      checkVec("m_vec_hold", m_vec, expVec);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    expCnt  = (expCnt + 1) & 32'hFFFF;
    checkOutput("m_valid_fall", {31'b0, m_valid}, 32'd0);
    checkOutput("s_ready_refill", {31'b0, s_ready}, 32'd1);
    checkOutput("frame_cnt", {16'b0, frame_cnt}, 32'(expCnt));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_s_ready"}, {31'b0, s_ready}, 32'd0);
    checkOutput({tag, "_m_valid"}, {31'b0, m_valid}, 32'd0);
    checkOutput({tag, "_err_len"}, {31'b0, err_len}, 32'd0);
    checkOutput({tag, "_frame_cnt"}, {16'b0, frame_cnt}, 32'd0);
    checkVec({tag, "_m_vec"}, m_vec, '0);
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;

    // Reset
    repeat (3) tick();
    checkResetValues("reset");
    rst_n = 1'b1;
    #1;
    checkOutput("s_ready_after_reset", {31'b0, s_ready}, 32'd1);

    // Indexed frame with m_ready already high
    m_ready = 1'b1;
    pushFrame(NUM_WORDS, NUM_WORDS - 1, 1'b1);
    checkOutput("t1_m_valid", {31'b0, m_valid}, 32'd1);
    checkOutput("t1_slice0", m_vec[31:0], 32'd0);
    checkOutput("t1_slice1", m_vec[63:32], 32'd1);
    checkOutput("t1_slice59", {26'b0, m_vec[1893:1888]}, 32'h3B);
    checkVec("t1_vec", m_vec, modelVec());
    tick();
    m_ready = 1'b0;
    expCnt = 1;
    checkOutput("t1_m_valid_fall", {31'b0, m_valid}, 32'd0);
    checkOutput("t1_frame_cnt", {16'b0, frame_cnt}, 32'd1);

    // Back-pressure: held for 10 cycles with s_valid high
    pushFrame(NUM_WORDS, NUM_WORDS - 1, 1'b0);
    deliverCheck(10);

    // Early s_last on word 10
    pushFrame(11, 10, 1'b0);
    checkOutput("early_err", {31'b0, err_len}, 32'd1);
    checkOutput("early_m_valid", {31'b0, m_valid}, 32'd0);
    tick();
    checkOutput("early_err_one_cycle", {31'b0, err_len}, 32'd0);
    pushFrame(NUM_WORDS, NUM_WORDS - 1, 1'b0);
    deliverCheck(0);

    // Early s_last at the second-to-last slice
    pushFrame(NUM_WORDS - 1, NUM_WORDS - 2, 1'b0);
    checkOutput("early58_err", {31'b0, err_len}, 32'd1);
    checkOutput("early58_m_valid", {31'b0, m_valid}, 32'd0);

    // Missing s_last, then three drained words
    pushFrame(NUM_WORDS, -1, 1'b0);
    checkOutput("miss_err", {31'b0, err_len}, 32'd1);
    checkOutput("miss_m_valid", {31'b0, m_valid}, 32'd0);
    applyStimulus($urandom, 1'b0);
    checkOutput("drain_err_clear", {31'b0, err_len}, 32'd0);
    applyStimulus($urandom, 1'b0);
    applyStimulus($urandom, 1'b1);
    checkOutput("drain_m_valid", {31'b0, m_valid}, 32'd0);
    checkOutput("drain_frame_cnt", {16'b0, frame_cnt}, 32'(expCnt));
    pushFrame(NUM_WORDS, NUM_WORDS - 1, 1'b0);
    deliverCheck(0);

    // Flush mid-frame at word 30 with a simultaneous input word
    pushFrame(30, -1, 1'b0);
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = $urandom;
    tick();
    flush   = 1'b0;
    s_valid = 1'b0;
    checkOutput("flush_fill_m_valid", {31'b0, m_valid}, 32'd0);
    checkOutput("flush_fill_err", {31'b0, err_len}, 32'd0);
    checkOutput("flush_fill_cnt", {16'b0, frame_cnt}, 32'(expCnt));
    pushFrame(NUM_WORDS, NUM_WORDS - 1, 1'b0);
    deliverCheck(0);

    // Flush while FULL with m_ready in the same cycle
    pushFrame(NUM_WORDS, NUM_WORDS - 1, 1'b0);
    checkOutput("flush_full_pre", {31'b0, m_valid}, 32'd1);
    flush   = 1'b1;
    m_ready = 1'b1;
    tick();
    flush   = 1'b0;
    m_ready = 1'b0;
    checkOutput("flush_full_m_valid", {31'b0, m_valid}, 32'd0);
    checkOutput("flush_full_cnt", {16'b0, frame_cnt}, 32'(expCnt));
    checkOutput("flush_full_err", {31'b0, err_len}, 32'd0);
    checkOutput("flush_full_s_ready", {31'b0, s_ready}, 32'd1);
    tick();
    checkOutput("flush_full_err_late", {31'b0, err_len}, 32'd0);

    // Random good frames with random hand-off delay
    for (int f = 0; f < 4; f++) begin
      pushFrame(NUM_WORDS, NUM_WORDS - 1, 1'b0);
      deliverCheck(int'($urandom_range(0, 3)));
    end

    // Reset pulse at word 45, then a clean frame
    pushFrame(45, -1, 1'b0);
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = $urandom;
    tick();
    checkResetValues("midreset");
    rst_n   = 1'b1;
    s_valid = 1'b0;
    expCnt  = 0;
    #1;
    checkOutput("midreset_s_ready", {31'b0, s_ready}, 32'd1);
    pushFrame(NUM_WORDS, NUM_WORDS - 1, 1'b0);
    deliverCheck(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cluster_input_loader.md
Name: cluster_input_loader

Overview:
- Assembles the 1894-bit cluster input vector from a narrow 32-bit word stream.
- Presents the assembled vector, held stable, to the combinational output-bit modules of CPU cluster_1 (module_output_bit_*).
- Sits directly upstream of those modules; it is the only sequential element on their input side.
- Uses valid/ready on both sides and detects malformed frames.

Parameters:
- VEC_W, 1894, width of assembled vector, equal to the cluster input width.
- WORD_W, 32, input word width.
- NUM_WORDS, ceil(VEC_W/WORD_W) = 60, words per frame. Derived; not overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  WORD_W  input word; word k carries vector bits [32k+31:32k].
- s_last  in  1  marks the final word of a frame.
- flush  in  1  synchronous abort of the current frame.
- m_valid  out  1  assembled vector valid.
- m_ready  in  1  downstream consumed the vector.
- m_vec  out  VEC_W  assembled vector; drives i[1893:0] of the output-bit modules.
- err_len  out  1  one-cycle pulse on a malformed frame.
- frame_cnt  out  16  count of frames delivered, wraps at 65535 -> 0.

Behaviour:
- One clock. Reset is synchronous and active-low: rst_n is sampled on rising clk; when low, all state clears on that edge.
- Reset values: state=FILL, word index=0, s_ready=0 during reset and 1 from the first cycle after rst_n is high, m_valid=0, m_vec=0, err_len=0, frame_cnt=0.
- Transfers occur on cycles with s_valid&&s_ready (input side) or m_valid&&m_ready (output side).
- States:
  - FILL: s_ready=1, m_valid=0. Each input transfer writes s_data into slice idx, then idx++.
  - FULL: s_ready=0, m_valid=1, m_vec stable. On an output transfer: go to FILL, idx=0, frame_cnt++.
  - DRAIN: s_ready=1, words discarded, m_valid=0. Exit to FILL with idx=0 on an input transfer with s_last=1.
- Normal completion: an input transfer at idx=59 with s_last=1 goes to FULL. m_valid rises the cycle after that transfer, so latency is 1 cycle from last word to m_valid.
- Last word: only bits [5:0] of word 59 are stored (vector bits 1893:1888). Bits [31:6] are ignored.
- Early s_last (transfer with s_last=1 at idx<59):
  - err_len pulses the next cycle.
  - Partial frame discarded: idx=0, stay FILL.
  - m_vec is not cleared; stale bits are not observable because m_valid stays 0.
- Missing s_last (transfer at idx=59 with s_last=0):
  - err_len pulses the next cycle.
  - Go to DRAIN. Frame discarded; frame_cnt unchanged.
- flush=1 in any state, on that edge:
  - idx=0, state=FILL, m_valid=0.
  - frame_cnt unchanged, no err_len.
  - flush has priority over a simultaneous input or output transfer, which is dropped.
- rst_n low mid-frame or in FULL: everything returns to reset values. Reset has priority over flush.
- m_vec changes only in FILL/DRAIN. It is never modified while m_valid=1.
- No bubble-free overlap: s_ready=0 throughout FULL. Throughput is one frame per 60 words + 1 output handshake cycle minimum.
- err_len is registered and never asserts for two consecutive cycles from one event.

Decomposition:
- Shared package cluster_pkg:
  - VEC_W=1894, WORD_W=32, NUM_WORDS=60, LAST_BITS=6.
  - Enum loader_state_t {FILL, FULL, DRAIN}.
- One natural sub-module: cluster_word_slicer, a combinational word-to-slice write-enable decode (idx -> 60-bit one-hot, with last-slice masking). The FSM and counters stay in the top.

Test Plan:
- Reset then 60 words (word k = k, s_last on word 59), m_ready=1 -> m_valid high 1 cycle after word 59; m_vec[31:0]=0, m_vec[63:32]=1, m_vec[1893:1888]=59[5:0]=6'h3B; frame_cnt=1.
- Same frame with m_ready=0 for 10 cycles, s_valid held high -> s_ready=0 throughout, m_vec constant; on m_ready=1, one output transfer then s_ready=1 next cycle.
- s_last on word 10 -> err_len=1 for exactly one cycle, m_valid stays 0; next full 60-word frame delivers correctly, frame_cnt=1.
- 60 words without s_last, then 3 more words with s_last on the third -> err_len pulse after word 59, 3 words discarded, following good frame delivered intact.
- flush asserted at word 30, and separately while FULL with m_ready=1 in the same cycle -> idx=0, m_valid=0 next cycle, frame_cnt unchanged, no err_len.
- rst_n low for 1 cycle at word 45, then a full frame -> outputs equal reset values during reset; the frame after reset is delivered with all 1894 bits matching the stimulus.
